// File: rtl/dl_mem_arbiter.sv
// dl_mem_arbiter
// Shares one single-port synchronous RAM (BIOS / sprite ROM region) between
// the HPS ioctl download stream and the core CPU. Download bytes are queued
// in a small FIFO so HPS writes survive while the CPU owns the RAM port, and
// a completion pulse is raised once the session has ended and drained.
// Optional build macro: DL_CHECKSUM_EN adds dn_checksum, a mod-2^16 sum of
// every byte accepted in the current session.
module dl_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int MATCH_INDEX = 0,
  parameter int STARVE_MAX  = 3
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_download,
  input  logic [7:0]        dn_index,
  input  logic [24:0]       dn_addr,
  input  logic [7:0]        dn_data,
  input  logic              dn_wr,
  output logic              dn_wait,
  output logic              dn_busy,
  output logic              dn_done,
  output logic [ADDR_W:0]   dn_count,
  output logic              dn_ovf,
`ifdef DL_CHECKSUM_EN
  output logic [15:0]       dn_checksum,
`endif
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 2);
  localparam int ENT_W = ADDR_W + 8;

  localparam logic [7:0]       MATCH_IDX  = 8'(MATCH_INDEX);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_WR,
    ST_CPU_RD,
    ST_CPU_RDW,
    ST_DL_WR
  } state_t;

  // FIFO storage and control
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [ENT_W-1:0] head;

  // Session state
  logic             sess_q;
  logic             busy_q;
  logic [ADDR_W:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
`ifdef DL_CHECKSUM_EN
  logic [15:0]      csum_q, csum_d;
`endif

  // Arbiter state and registered RAM / CPU outputs
  state_t            state_q;
  logic [ST_W-1:0]   starve_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic              mem_we_q;
  logic              cpu_ack_q;
  logic [7:0]        cpu_dout_q;

  logic match, in_range, fifo_full, fifo_empty;
  logic push, pop, dl_err, sess_start;

  // A byte is only ours while a download for our index is active; anything
  // at or beyond the RAM size cannot be stored and is flagged instead.
  assign match      = dn_download && (dn_index == MATCH_IDX);
  assign in_range   = (dn_addr >> ADDR_W) == 25'd0;
  assign fifo_full  = (fifo_cnt_q == FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = dn_wr && match && in_range && !fifo_full;
  assign dl_err     = dn_wr && match && (!in_range || fifo_full);
  assign sess_start = match && !sess_q;

  // The download wins the idle port unless the CPU is asking and has not yet
  // used up its allowance of consecutive grants over a waiting FIFO.
  assign pop  = (state_q == ST_IDLE) && !fifo_empty &&
                (!cpu_req || (starve_q == STARVE_LIM));
  assign head = fifo_mem[rd_ptr_q];

  assign dn_wait  = fifo_full;
  assign dn_busy  = sess_q || !fifo_empty;
  assign dn_done  = busy_q && !dn_busy;
  assign dn_count = count_q;
  assign dn_ovf   = ovf_q;
`ifdef DL_CHECKSUM_EN
  assign dn_checksum = csum_q;
`endif
  assign cpu_dout = cpu_dout_q;
  assign cpu_ack  = cpu_ack_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;

  // FIFO payload: address and byte of each accepted download write
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {dn_addr[ADDR_W-1:0], dn_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Next-state of the session statistics: a new session clears them first,
  // so a byte accepted on the very first cycle still counts
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (sess_start) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (push)   count_d = count_d + 1'b1;
    if (dl_err) ovf_d   = 1'b1;
  end

`ifdef DL_CHECKSUM_EN
  // Next-state of the running byte sum, restarted with each session
  always_comb begin
    csum_d = csum_q;
    if (sess_start) csum_d = '0;
    if (push)       csum_d = csum_d + 16'(dn_data);
  end
`endif

  // Session registers: active flag, busy history for the done pulse, stats
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sess_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
`ifdef DL_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      sess_q  <= match;
      busy_q  <= dn_busy;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef DL_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Port arbiter: one RAM operation issued on each state entry, all RAM and
  // CPU-facing outputs registered
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q    <= ST_DL_WR;
            mem_addr_q <= head[ENT_W-1:8];
            mem_din_q  <= head[7:0];
            mem_we_q   <= 1'b1;
            starve_q   <= '0;
          end else if (cpu_req) begin
            mem_addr_q <= cpu_addr;
            mem_din_q  <= cpu_din;
            if (!fifo_empty && (starve_q != STARVE_LIM)) begin
              starve_q <= starve_q + 1'b1;
            end
            if (cpu_we) begin
              state_q   <= ST_CPU_WR;
              mem_we_q  <= 1'b1;
              cpu_ack_q <= 1'b1;
            end else begin
              state_q <= ST_CPU_RD;
            end
          end
        end
        ST_CPU_RD:  state_q <= ST_CPU_RDW;
        ST_CPU_RDW: begin
          cpu_dout_q <= mem_dout;
          cpu_ack_q  <= 1'b1;
          state_q    <= ST_IDLE;
        end
        ST_CPU_WR:  state_q <= ST_IDLE;
        ST_DL_WR:   state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_mem_arbiter.sv
// Testbench for dl_mem_arbiter: directed vectors against a behavioural
// single-port RAM with 1-cycle read latency.
module tb_dl_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dn_download = 1'b0;
  logic [7:0]  dn_index = 8'd0;
  logic [24:0] dn_addr = 25'd0;
  logic [7:0]  dn_data = 8'd0;
  logic        dn_wr = 1'b0;
  logic        dn_wait, dn_busy, dn_done, dn_ovf;
  logic [16:0] dn_count;
`ifdef DL_CHECKSUM_EN
  logic [15:0] dn_checksum;
`endif
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic [7:0]  cpu_din = 8'd0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout = 8'd0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:65535];
  logic [15:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          ev_q [$];
  int          done_cnt = 0;
  int          done_wr = 0;

  logic [54:0] all_outs;
  assign all_outs = {dn_wait, dn_busy, dn_done, dn_count, dn_ovf, cpu_dout,
                     cpu_ack, mem_addr, mem_din, mem_we};

  dl_mem_arbiter #(
    .ADDR_W(16), .FIFO_DEPTH(4), .MATCH_INDEX(0), .STARVE_MAX(3)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n),
    .dn_download(dn_download), .dn_index(dn_index), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_wr(dn_wr), .dn_wait(dn_wait), .dn_busy(dn_busy),
    .dn_done(dn_done), .dn_count(dn_count), .dn_ovf(dn_ovf),
`ifdef DL_CHECKSUM_EN
    .dn_checksum(dn_checksum),
`endif
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_pat(input logic [15:0] a);
    return 8'(a * 16'd7 + 16'd3);
  endfunction

  // Behavioural synchronous RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[16'h3000 + i] <= rd_pat(16'h3000 + 16'(i));
  end

  // Event log of the completed cycle
  always @(posedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_din);
      ev_q.push_back(1);
    end
    if (cpu_ack) ev_q.push_back(2);
    if (dn_done) begin
      done_cnt++;
      done_wr = wa_q.size();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
    int g;
    g = 0;
    while (dn_wait && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) tmo_fail("push_wait");
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    @(negedge clk);
    dn_wr = 1'b0;
  endtask

  task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] d,
                        output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 20);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    int          exp_lat;
  } cpu_vec_t;

  cpu_vec_t vec [7];

  initial begin
    int lat, g, nd, acks;
    int between [4];

    vec[0] = '{1'b1, 16'h0100, 8'h55, 8'h00, 1};
    vec[1] = '{1'b0, 16'h0100, 8'h00, 8'h55, 3};
    vec[2] = '{1'b1, 16'hFFFF, 8'hAA, 8'h00, 1};
    vec[3] = '{1'b0, 16'hFFFF, 8'h00, 8'hAA, 3};
    vec[4] = '{1'b1, 16'h0000, 8'h3C, 8'h00, 1};
    vec[5] = '{1'b0, 16'h0000, 8'h00, 8'h3C, 3};
    vec[6] = '{1'b0, 16'h0100, 8'h00, 8'h55, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(all_outs), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: asynchronous reset with three entries queued behind CPU reads
    wa_q.delete(); wd_q.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    dn_download = 1'b1; dn_index = 8'd0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dn_wr = 1'b1; dn_addr = 25'h40 + 25'(i); dn_data = 8'h11 * 8'(i + 1);
      @(negedge clk);
    end
    dn_wr = 1'b0;
    chk("t1_count_before", 64'(dn_count), 64'd3);
    chk("t1_no_dl_write_yet", 64'(wa_q.size()), 64'd0);
    #2 reset_n = 1'b0;
    #1 chk("t1_async_reset_outs", 64'(all_outs), 64'd0);
    dn_download = 1'b0; cpu_req = 1'b0;
    @(negedge clk); @(negedge clk);
    wa_q.delete(); wd_q.delete();
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t1_busy_after", 64'(dn_busy), 64'd0);
    chk("t1_no_stale_write", 64'(wa_q.size()), 64'd0);

    // T5: foreign index ignored, out-of-range address flagged
    wa_q.delete(); wd_q.delete();
    dn_download = 1'b1; dn_index = 8'd3;
    for (int i = 0; i < 5; i++) push_byte(25'(i), 8'h50 + 8'(i));
    repeat (3) @(negedge clk);
    chk("t5_count", 64'(dn_count), 64'd0);
    chk("t5_busy", 64'(dn_busy), 64'd0);
    chk("t5_writes", 64'(wa_q.size()), 64'd0);
    dn_index = 8'd0;
    @(negedge clk);
    push_byte(25'h10000, 8'h77);
    repeat (2) @(negedge clk);
    chk("t5_ovf", 64'(dn_ovf), 64'd1);
    chk("t5_count_ovf", 64'(dn_count), 64'd0);
    chk("t5_writes_ovf", 64'(wa_q.size()), 64'd0);
    dn_download = 1'b0;
    repeat (4) @(negedge clk);

    // T2: ten-byte download with no CPU traffic
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    dn_download = 1'b1; dn_index = 8'd0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) push_byte(25'(i), 8'hA0 + 8'(i));
    dn_download = 1'b0;
    g = 0;
    while (done_cnt == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) tmo_fail("t2_done_wait");
    repeat (3) @(negedge clk);
    chk("t2_nwrites", 64'(wa_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < wa_q.size(); i++) begin
      chk($sformatf("t2_write[%0d]", i), 64'({wa_q[i], wd_q[i]}),
          64'({16'(i), 8'hA0 + 8'(i)}));
    end
    chk("t2_count", 64'(dn_count), 64'd10);
    chk("t2_ovf_cleared", 64'(dn_ovf), 64'd0);
    chk("t2_done_once", 64'(done_cnt), 64'd1);
    chk("t2_done_after_last", 64'(done_wr), 64'd10);
    chk("t2_busy_end", 64'(dn_busy), 64'd0);

    // T4: CPU write/read table
    for (int i = 0; i < 7; i++) begin
      cpu_op(vec[i].we, vec[i].addr, vec[i].din, lat);
      chk($sformatf("t4_lat[%0d]", i), 64'(lat), 64'(vec[i].exp_lat));
      if (vec[i].we) begin
        chk($sformatf("t4_mem_we[%0d]", i), 64'(mem_we), 64'd1);
        chk($sformatf("t4_mem_addr[%0d]", i), 64'(mem_addr), 64'(vec[i].addr));
        chk($sformatf("t4_mem_din[%0d]", i), 64'(mem_din), 64'(vec[i].din));
      end else begin
        chk($sformatf("t4_dout[%0d]", i), 64'(cpu_dout), 64'(vec[i].exp_dout));
      end
      cpu_req = 1'b0;
      @(negedge clk);
    end

    // T3: CPU reads back-to-back while a 4-byte burst waits for the port
    wa_q.delete(); wd_q.delete(); ev_q.delete();
    dn_download = 1'b1; dn_index = 8'd0;
    @(negedge clk);
    fork
      begin : cpu_proc
        int t;
        for (int k = 0; k < 20; k++) begin
          cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000 + 16'(k);
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!cpu_ack && t < 50);
          if (t >= 50) tmo_fail("t3_cpu_ack");
          chk($sformatf("t3_rd[%0d]", k), 64'(cpu_dout), 64'(rd_pat(16'h3000 + 16'(k))));
        end
        cpu_req = 1'b0;
      end
      begin : dl_proc
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          dn_wr = 1'b1; dn_addr = 25'h200 + 25'(i); dn_data = 8'hC0 + 8'(i);
          @(negedge clk);
        end
        dn_wr = 1'b0;
        chk("t3_wait_full", 64'(dn_wait), 64'd1);
        dn_wr = 1'b1; dn_addr = 25'h204; dn_data = 8'hC4;
        @(negedge clk);
        dn_wr = 1'b0;
        chk("t3_ovf_full", 64'(dn_ovf), 64'd1);
        chk("t3_count_full", 64'(dn_count), 64'd4);
      end
    join
    g = 0;
    while (wa_q.size() < 4 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) tmo_fail("t3_write_wait");
    repeat (3) @(negedge clk);
    chk("t3_nwrites", 64'(wa_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk($sformatf("t3_write[%0d]", i), 64'({wa_q[i], wd_q[i]}),
          64'({16'h0200 + 16'(i), 8'hC0 + 8'(i)}));
    end
    nd = 0; acks = 0;
    for (int j = 0; j < 4; j++) between[j] = 0;
    foreach (ev_q[j]) begin
      if (ev_q[j] == 1) begin
        if (nd > 0 && nd < 4) between[nd] = acks;
        nd++;
        acks = 0;
      end else begin
        acks++;
      end
    end
    chk("t3_dl_grants", 64'(nd), 64'd4);
    for (int j = 1; j < 4; j++) begin
      chk($sformatf("t3_cpu_between[%0d]", j), 64'(between[j]), 64'd3);
    end
    dn_download = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_busy_end", 64'(dn_busy), 64'd0);

`ifdef DL_CHECKSUM_EN
    // T6: checksum of 300 bytes of 0xFF
    dn_download = 1'b1; dn_index = 8'd0;
    @(negedge clk);
    for (int i = 0; i < 300; i++) push_byte(25'(i), 8'hFF);
    repeat (2) @(negedge clk);
    chk("t6_checksum", 64'(dn_checksum), 64'h2AD4);
    chk("t6_count", 64'(dn_count), 64'd300);
    dn_download = 1'b0;
    repeat (700) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
